// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage with a request/grant/response instruction-memory
// port. Holds PCF, keeps at most one memory request outstanding, parks a
// response in a one-entry hold buffer while decode is stalled, and throws
// away wrong-path responses after an execute-stage redirect.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   PCSrcE      redirect request from execute
//   PCTargetE   redirect target address
//   StallF      freeze PCF and issue no new request
//   StallD      hold IF/ID contents
//   FlushD      load a bubble into IF/ID
//   imem_req    fetch request valid
//   imem_addr   fetch address (PCF, or PCF+4 on back-to-back issue)
//   imem_gnt    request accepted this cycle (only meaningful with imem_req)
//   imem_rvalid response valid, one per granted request, in order
//   imem_rdata  instruction word
//   InstrD      IF/ID instruction (NOP_INSTR when not valid)
//   PCD         IF/ID PC
//   PCPlus4D    IF/ID PC+4
//   ValidD      IF/ID holds a real instruction
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // nothing outstanding
    S_WAIT  = 2'd1,  // one granted, awaiting its response
    S_HOLD  = 2'd2,  // response parked, decode stalled
    S_DRAIN = 2'd3   // one granted, its response is wrong-path
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pcf_reg, pcf_next;
  logic [31:0] hold_instr_reg, hold_instr_next;
  logic [31:0] hold_pc_reg, hold_pc_next;

  logic [31:0] instr_d_reg, instr_d_next;
  logic [31:0] pc_d_reg, pc_d_next;
  logic [31:0] pc_plus4_d_reg, pc_plus4_d_next;
  logic        valid_d_reg, valid_d_next;

  logic [31:0] pcf_plus4;
  logic        req_raw;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc;

  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
  assign pcf_plus4 = pcf_reg + 32'd4;

  // ---------------------------------------------------------------------
  // Next-state, PCF and memory-port logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    pcf_next        = pcf_reg;
    hold_instr_next = hold_instr_reg;
    hold_pc_next    = hold_pc_reg;
    req_raw         = 1'b0;
    imem_addr       = pcf_reg;
    deliver         = 1'b0;
    deliver_instr   = hold_instr_reg;
    deliver_pc      = hold_pc_reg;

    case (state_reg)
      S_REQ: begin
        if (PCSrcE) begin
          // No request on a redirect cycle; the new PCF is fetched next cycle.
          pcf_next = PCTargetE;
        end else begin
          req_raw = !StallF;
          if (!StallF && imem_gnt) begin
            state_next = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (PCSrcE) begin
          pcf_next = PCTargetE;
          // A response arriving now is simply dropped; otherwise it is still
          // in flight and must be drained before a new request may go out.
          state_next = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          if (StallD) begin
            hold_instr_next = imem_rdata;
            hold_pc_next    = pcf_reg;
            state_next      = S_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            deliver_pc    = pcf_reg;
            pcf_next      = pcf_plus4;
            // Back-to-back issue of the next sequential word keeps a
            // zero-wait memory at one instruction per cycle.
            req_raw       = !StallF;
            imem_addr     = pcf_plus4;
            state_next    = (!StallF && imem_gnt) ? S_WAIT : S_REQ;
          end
        end
      end

      S_HOLD: begin
        if (PCSrcE) begin
          pcf_next   = PCTargetE;
          state_next = S_REQ;
        end else if (!StallD) begin
          deliver    = 1'b1;
          pcf_next   = pcf_plus4;
          state_next = S_REQ;
        end
      end

      S_DRAIN: begin
        if (PCSrcE) begin
          pcf_next = PCTargetE;
        end
        if (imem_rvalid) begin
          state_next = S_REQ;
        end
      end

      default: begin
        state_next = S_REQ;
      end
    endcase

    // No request may be presented while the stage is held in reset.
    imem_req = req_raw && rst;
  end

  // ---------------------------------------------------------------------
  // IF/ID register next value: flush/redirect beats stall beats delivery
  // ---------------------------------------------------------------------
  always_comb begin
    instr_d_next    = NOP_INSTR;
    pc_d_next       = 32'd0;
    pc_plus4_d_next = 32'd0;
    valid_d_next    = 1'b0;
    if (FlushD || PCSrcE) begin
      instr_d_next    = NOP_INSTR;
    end else if (StallD) begin
      instr_d_next    = instr_d_reg;
      pc_d_next       = pc_d_reg;
      pc_plus4_d_next = pc_plus4_d_reg;
      valid_d_next    = valid_d_reg;
    end else if (deliver) begin
      instr_d_next    = deliver_instr;
      pc_d_next       = deliver_pc;
      pc_plus4_d_next = deliver_pc + 32'd4;
      valid_d_next    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_REQ;
      pcf_reg        <= RESET_PC;
      hold_instr_reg <= NOP_INSTR;
      hold_pc_reg    <= 32'd0;
      instr_d_reg    <= NOP_INSTR;
      pc_d_reg       <= 32'd0;
      pc_plus4_d_reg <= 32'd0;
      valid_d_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pcf_reg        <= pcf_next;
      hold_instr_reg <= hold_instr_next;
      hold_pc_reg    <= hold_pc_next;
      instr_d_reg    <= instr_d_next;
      pc_d_reg       <= pc_d_next;
      pc_plus4_d_reg <= pc_plus4_d_next;
      valid_d_reg    <= valid_d_next;
    end
  end

  assign InstrD   = instr_d_reg;
  assign PCD      = pc_d_reg;
  assign PCPlus4D = pc_plus4_d_reg;
  assign ValidD   = valid_d_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit. A small instruction-memory responder grants
// every request at once and answers each grant a programmable number of
// cycles later with instr_at(addr). Inputs change on the falling edge and
// outputs are sampled 1 ns after it.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'd0;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int checks   = 0;
  int failures = 0;

  // Memory responder configuration (written only by the stimulus process).
  int lat            = 1;
  bit gnt_en         = 1'b1;
  bit flush_on_reset = 1'b1;

  // Memory responder state (written only by the responder process).
  bit          pend      = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_cnt  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  assign imem_gnt = imem_req & gnt_en;

  // Responder: a grant at edge E with latency L raises rvalid for the
  // cycle that starts L edges after the granting cycle.
  always @(posedge clk) begin : mem_model
    logic        g;
    logic        r;
    logic [31:0] a;
    g = imem_req & imem_gnt;
    a = imem_addr;
    r = imem_rvalid;
    #1;
    if (!rst && flush_on_reset) pend = 1'b0;
    if (r) pend = 1'b0;
    if (g) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_cnt  = lat;
    end
    if (pend) begin
      pend_cnt    = pend_cnt - 1;
      imem_rvalid = (pend_cnt == 0);
      imem_rdata  = (pend_cnt == 0) ? instr_at(pend_addr) : 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // One line per instruction handed to decode.
  always @(negedge clk) begin
    if (rst && ValidD) $display("IFID pc=%h instr=%h pc4=%h", PCD, InstrD, PCPlus4D);
  end

  task automatic apply_reset(input int latency);
    @(negedge clk);
    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    lat = latency; flush_on_reset = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    @(negedge clk); #1;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++;
    if (imem_addr !== 32'd0) begin failures++; $display("FAIL rst_addr: got %h expected 00000000", imem_addr); end
    checks++;
    if (InstrD !== NOP) begin failures++; $display("FAIL rst_instr: got %h expected %h", InstrD, NOP); end
    checks++;
    if (PCD !== 32'd0) begin failures++; $display("FAIL rst_pcd: got %h expected 00000000", PCD); end
    checks++;
    if (PCPlus4D !== 32'd0) begin failures++; $display("FAIL rst_pc4: got %h expected 00000000", PCPlus4D); end
    checks++;
    if (ValidD !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", ValidD); end
    checks++;
  endtask

  // Zero-wait memory: addresses 0,4,8,... each cycle, decode sees PCD two
  // cycles after the matching request.
  task automatic test_zero_wait;
    logic [31:0] ep;
    bit          ev;
    apply_reset(1);
    for (int k = 0; k < 6; k++) begin
      #1;
      ev = (k >= 2);
      ep = ev ? 32'(4 * (k - 2)) : 32'd0;
      if (imem_req !== 1'b1) begin failures++; $display("FAIL zw_req k=%0d: got %b expected 1", k, imem_req); end
      checks++;
      if (imem_addr !== 32'(4 * k)) begin failures++; $display("FAIL zw_addr k=%0d: got %h expected %h", k, imem_addr, 32'(4 * k)); end
      checks++;
      if (ValidD !== ev) begin failures++; $display("FAIL zw_valid k=%0d: got %b expected %b", k, ValidD, ev); end
      checks++;
      if (PCD !== ep) begin failures++; $display("FAIL zw_pcd k=%0d: got %h expected %h", k, PCD, ep); end
      checks++;
      if (InstrD !== (ev ? instr_at(ep) : NOP)) begin failures++; $display("FAIL zw_instr k=%0d: got %h expected %h", k, InstrD, ev ? instr_at(ep) : NOP); end
      checks++;
      @(negedge clk);
    end
  endtask

  // Four-cycle memory: one request every 4 cycles, one valid every 4 cycles.
  task automatic test_latency;
    logic [31:0] ep;
    bit          er, ev;
    apply_reset(4);
    for (int k = 0; k < 14; k++) begin
      #1;
      er = (k % 4 == 0);
      ev = (k >= 5) && ((k - 5) % 4 == 0);
      ep = ev ? 32'(k - 5) : 32'd0;
      if (imem_req !== er) begin failures++; $display("FAIL lat_req k=%0d: got %b expected %b", k, imem_req, er); end
      checks++;
      if (er && imem_addr !== 32'(k)) begin failures++; $display("FAIL lat_addr k=%0d: got %h expected %h", k, imem_addr, 32'(k)); end
      if (er) checks++;
      if (ValidD !== ev) begin failures++; $display("FAIL lat_valid k=%0d: got %b expected %b", k, ValidD, ev); end
      checks++;
      if (PCD !== ep) begin failures++; $display("FAIL lat_pcd k=%0d: got %h expected %h", k, PCD, ep); end
      checks++;
      @(negedge clk);
    end
  endtask

  // Decode stall of 3 cycles while the response for 0x10 arrives.
  task automatic test_stall_hold;
    bit          er [12] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    logic [31:0] ea [12] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h14, 32'h18, 32'h1C};
    bit          ev [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    logic [31:0] ep [12] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'h10, 32'h0, 32'h14};
    apply_reset(1);
    for (int k = 0; k < 12; k++) begin
      StallD = (k >= 5 && k <= 7);
      #1;
      if (imem_req !== er[k]) begin failures++; $display("FAIL hold_req k=%0d: got %b expected %b", k, imem_req, er[k]); end
      checks++;
      if (er[k] && imem_addr !== ea[k]) begin failures++; $display("FAIL hold_addr k=%0d: got %h expected %h", k, imem_addr, ea[k]); end
      if (er[k]) checks++;
      if (ValidD !== ev[k]) begin failures++; $display("FAIL hold_valid k=%0d: got %b expected %b", k, ValidD, ev[k]); end
      checks++;
      if (PCD !== ep[k]) begin failures++; $display("FAIL hold_pcd k=%0d: got %h expected %h", k, PCD, ep[k]); end
      checks++;
      if (InstrD !== (ev[k] ? instr_at(ep[k]) : NOP)) begin failures++; $display("FAIL hold_instr k=%0d: got %h expected %h", k, InstrD, ev[k] ? instr_at(ep[k]) : NOP); end
      checks++;
      if (PCPlus4D !== (ev[k] ? ep[k] + 32'd4 : 32'd0)) begin failures++; $display("FAIL hold_pc4 k=%0d: got %h expected %h", k, PCPlus4D, ev[k] ? ep[k] + 32'd4 : 32'd0); end
      checks++;
      @(negedge clk);
    end
    StallD = 1'b0;
  endtask

  // Redirect to 0x100 while waiting: old response is drained and dropped.
  task automatic test_redirect_drain;
    bit          er [11] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    logic [31:0] ea [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h104, 32'h0};
    apply_reset(4);
    for (int k = 0; k < 11; k++) begin
      PCSrcE    = (k == 1);
      PCTargetE = (k == 1) ? 32'h100 : 32'd0;
      #1;
      if (imem_req !== er[k]) begin failures++; $display("FAIL redir_req k=%0d: got %b expected %b", k, imem_req, er[k]); end
      checks++;
      if (er[k] && imem_addr !== ea[k]) begin failures++; $display("FAIL redir_addr k=%0d: got %h expected %h", k, imem_addr, ea[k]); end
      if (er[k]) checks++;
      if (ValidD !== (k == 10)) begin failures++; $display("FAIL redir_valid k=%0d: got %b expected %b", k, ValidD, k == 10); end
      checks++;
      if (k == 10 && (PCD !== 32'h100 || InstrD !== instr_at(32'h100))) begin
        failures++; $display("FAIL redir_deliver: got pc=%h instr=%h expected pc=00000100 instr=%h", PCD, InstrD, instr_at(32'h100));
      end
      if (k == 10) checks++;
      @(negedge clk);
    end
  endtask

  // Redirect to the top word: PCPlus4D and the next fetch address wrap to 0.
  task automatic test_wrap;
    bit          er [5] = '{1, 0, 1, 1, 1};
    logic [31:0] ea [5] = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4};
    apply_reset(1);
    for (int k = 0; k < 5; k++) begin
      PCSrcE    = (k == 1);
      PCTargetE = (k == 1) ? 32'hFFFF_FFFC : 32'd0;
      #1;
      if (imem_req !== er[k]) begin failures++; $display("FAIL wrap_req k=%0d: got %b expected %b", k, imem_req, er[k]); end
      checks++;
      if (er[k] && imem_addr !== ea[k]) begin failures++; $display("FAIL wrap_addr k=%0d: got %h expected %h", k, imem_addr, ea[k]); end
      if (er[k]) checks++;
      if (ValidD !== (k == 4)) begin failures++; $display("FAIL wrap_valid k=%0d: got %b expected %b", k, ValidD, k == 4); end
      checks++;
      @(negedge clk);
    end
    // Sampled at k=4 equivalent after stepping: re-check the delivered entry
    // one cycle later is gone (bubble) while the wrapped values were seen.
  endtask

  task automatic test_wrap_values;
    apply_reset(1);
    PCSrcE = 1'b0;
    @(negedge clk);
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    @(negedge clk);
    PCSrcE = 1'b0; PCTargetE = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    if (PCD !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pcd: got %h expected fffffffc", PCD); end
    checks++;
    if (PCPlus4D !== 32'd0) begin failures++; $display("FAIL wrap_pc4: got %h expected 00000000", PCPlus4D); end
    checks++;
    if (InstrD !== 32'hC0DE_FFFC) begin failures++; $display("FAIL wrap_instr: got %h expected c0defffc", InstrD); end
    checks++;
  endtask

  // FlushD together with StallD: flush wins, then the parked word follows.
  task automatic test_flush_stall;
    apply_reset(1);
    repeat (2) @(negedge clk);
    #1;
    if (ValidD !== 1'b1 || PCD !== 32'd0) begin failures++; $display("FAIL fl_pre: got valid=%b pc=%h expected valid=1 pc=00000000", ValidD, PCD); end
    checks++;
    FlushD = 1'b1; StallD = 1'b1;
    @(negedge clk);
    FlushD = 1'b0; StallD = 1'b0;
    #1;
    if (InstrD !== NOP) begin failures++; $display("FAIL fl_instr: got %h expected %h", InstrD, NOP); end
    checks++;
    if (ValidD !== 1'b0) begin failures++; $display("FAIL fl_valid: got %b expected 0", ValidD); end
    checks++;
    if (PCD !== 32'd0 || PCPlus4D !== 32'd0) begin failures++; $display("FAIL fl_pc: got pc=%h pc4=%h expected 0/0", PCD, PCPlus4D); end
    checks++;
    @(negedge clk); #1;
    if (ValidD !== 1'b1 || PCD !== 32'h4 || InstrD !== instr_at(32'h4)) begin
      failures++; $display("FAIL fl_after: got valid=%b pc=%h instr=%h expected 1/00000004/%h", ValidD, PCD, InstrD, instr_at(32'h4));
    end
    checks++;
  endtask

  // Reset asserted while a request is outstanding; its late response must
  // be ignored and fetch restarts from RESET_PC.
  task automatic test_reset_mid_wait;
    apply_reset(4);
    repeat (5) @(negedge clk);
    #1;
    if (ValidD !== 1'b1 || PCD !== 32'd0) begin failures++; $display("FAIL rmw_pre: got valid=%b pc=%h expected 1/00000000", ValidD, PCD); end
    checks++;
    @(negedge clk);
    flush_on_reset = 1'b0;
    rst = 1'b0; StallF = 1'b1;
    #1;
    if (imem_req !== 1'b0 || ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'd0 || PCPlus4D !== 32'd0) begin
      failures++; $display("FAIL rmw_async: got req=%b valid=%b instr=%h pc=%h pc4=%h expected 0/0/%h/0/0", imem_req, ValidD, InstrD, PCD, PCPlus4D, NOP);
    end
    checks++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    if (ValidD !== 1'b0) begin failures++; $display("FAIL rmw_late: got valid=%b expected 0", ValidD); end
    checks++;
    @(negedge clk);
    StallF = 1'b0;
    flush_on_reset = 1'b1;
    #1;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++; $display("FAIL rmw_first: got req=%b addr=%h expected 1/00000000", imem_req, imem_addr); end
    checks++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      if (ValidD !== (k == 5)) begin failures++; $display("FAIL rmw_valid k=%0d: got %b expected %b", k, ValidD, k == 5); end
      checks++;
    end
    if (PCD !== 32'd0 || InstrD !== instr_at(32'd0)) begin failures++; $display("FAIL rmw_deliver: got pc=%h instr=%h expected 00000000/%h", PCD, InstrD, instr_at(32'd0)); end
    checks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_hold();
    test_redirect_drain();
    test_wrap();
    test_wrap_values();
    test_flush_stall();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
